// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: buffers strobed bytes from the UART core and
// presents them on a first-word-fall-through valid/ready read port.
module uart_rx_fifo #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_DEPTH      = 16,
  parameter int P_ADDR_WIDTH = 4,
  parameter int P_IRQ_LEVEL  = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [P_DATA_WIDTH-1:0] i_rx_data,
  input  logic                    i_rx_valid,
  output logic [P_DATA_WIDTH-1:0] o_rd_data,
  output logic                    o_rd_valid,
  input  logic                    i_rd_ready,
  input  logic                    i_flush,
  input  logic                    i_overflow_clr,
  output logic [P_ADDR_WIDTH:0]   o_count,
  output logic                    o_empty,
  output logic                    o_full,
  output logic                    o_overflow,
  output logic                    o_level_irq
);

  localparam logic [P_ADDR_WIDTH:0] C_FULL =
    (P_ADDR_WIDTH+1)'(P_DEPTH);
  localparam logic [P_ADDR_WIDTH:0] C_IRQ =
    (P_ADDR_WIDTH+1)'(P_IRQ_LEVEL);

  logic [P_DATA_WIDTH-1:0] mem [P_DEPTH];
  logic [P_ADDR_WIDTH-1:0] wr_ptr;
  logic [P_ADDR_WIDTH-1:0] rd_ptr;
  logic [P_ADDR_WIDTH:0]   count;
  logic                    overflow;

  logic not_empty;
  logic is_full;
  logic pop;
  logic push;
  logic drop;

  assign not_empty = (count != '0);
  assign is_full   = (count == C_FULL);
  assign pop       = not_empty & i_rd_ready & ~i_flush;
  // A pop frees the slot the incoming byte needs, even when full.
  assign push      = i_rx_valid & ~i_flush & (~is_full | pop);
  assign drop      = i_rx_valid & ~i_flush & is_full & ~pop;

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= i_rx_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (i_flush) begin
        rd_ptr <= wr_ptr;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (push && !pop) begin
          count <= count + 1'b1;
        end else if (pop && !push) begin
          count <= count - 1'b1;
        end
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (i_overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  assign o_rd_valid  = not_empty;
  assign o_rd_data   = not_empty ? mem[rd_ptr] : '0;
  assign o_count     = count;
  assign o_empty     = ~not_empty;
  assign o_full      = is_full;
  assign o_overflow  = overflow;
  assign o_level_irq = (count >= C_IRQ);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: vector table plus
// hand-written multi-cycle sequences.
module tb_uart_rx_fifo;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic       flush;
  logic       ovf_clr;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       level_irq;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  uart_rx_fifo #(
    .P_DATA_WIDTH(8),
    .P_DEPTH(16),
    .P_ADDR_WIDTH(4),
    .P_IRQ_LEVEL(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .i_rx_data(rx_data),
    .i_rx_valid(rx_valid),
    .o_rd_data(rd_data),
    .o_rd_valid(rd_valid),
    .i_rd_ready(rd_ready),
    .i_flush(flush),
    .i_overflow_clr(ovf_clr),
    .o_count(count),
    .o_empty(empty),
    .o_full(full),
    .o_overflow(overflow),
    .o_level_irq(level_irq)
  );

  typedef struct {
    logic       rst;
    logic       rxv;
    logic [7:0] rxd;
    logic       rdy;
    logic       fl;
    logic       oclr;
    int         e_cnt;
    logic       e_vld;
    logic [7:0] e_dat;
    logic       e_ovf;
  } vec_t;

  vec_t tbl [14];

  task automatic step(input logic rst, input logic rxv,
                      input logic [7:0] rxd, input logic rdy,
                      input logic fl, input logic oclr);
    reset    = rst;
    rx_valid = rxv;
    rx_data  = rxd;
    rd_ready = rdy;
    flush    = fl;
    ovf_clr  = oclr;
    @(posedge clock);
    #1;
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rd_ready = 1'b0;
    flush    = 1'b0;
    ovf_clr  = 1'b0;
  endtask

  task automatic chk(input string name, input int e_cnt,
                     input logic e_vld, input logic [7:0] e_dat,
                     input logic e_ovf);
    logic [16:0] got;
    logic [16:0] exp;
    logic [4:0]  ec;
    ec  = 5'(e_cnt);
    exp = {ec, e_vld, e_dat, e_ovf, (e_cnt == 0),
           (e_cnt == 16), (e_cnt >= 8)};
    got = {count, rd_valid, rd_data, overflow, empty,
           full, level_irq};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got cnt=%0d vld=%b dat=%h ovf=%b emp=%b ful=%b irq=%b, want %h (cnt=%0d vld=%b dat=%h ovf=%b)",
               name, count, rd_valid, rd_data, overflow, empty,
               full, level_irq, exp, e_cnt, e_vld, e_dat, e_ovf);
    end
  endtask

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    rd_ready = 1'b0; flush = 1'b0; ovf_clr = 1'b0;

    //            rst  rxv  rxd    rdy  fl   oclr cnt vld dat    ovf
    tbl[0]  = '{1'b1,1'b0,8'h00,1'b0,1'b0,1'b0, 0,1'b0,8'h00,1'b0};
    tbl[1]  = '{1'b0,1'b1,8'h41,1'b0,1'b0,1'b0, 1,1'b1,8'h41,1'b0};
    tbl[2]  = '{1'b0,1'b0,8'h00,1'b1,1'b0,1'b0, 0,1'b0,8'h00,1'b0};
    tbl[3]  = '{1'b0,1'b0,8'h00,1'b1,1'b0,1'b0, 0,1'b0,8'h00,1'b0};
    tbl[4]  = '{1'b0,1'b1,8'h41,1'b0,1'b0,1'b0, 1,1'b1,8'h41,1'b0};
    tbl[5]  = '{1'b0,1'b1,8'h42,1'b1,1'b0,1'b0, 1,1'b1,8'h42,1'b0};
    tbl[6]  = '{1'b0,1'b1,8'h43,1'b0,1'b0,1'b0, 2,1'b1,8'h42,1'b0};
    tbl[7]  = '{1'b0,1'b0,8'h00,1'b1,1'b0,1'b0, 1,1'b1,8'h43,1'b0};
    tbl[8]  = '{1'b0,1'b0,8'h00,1'b1,1'b0,1'b0, 0,1'b0,8'h00,1'b0};
    tbl[9]  = '{1'b0,1'b0,8'h00,1'b0,1'b0,1'b1, 0,1'b0,8'h00,1'b0};
    tbl[10] = '{1'b1,1'b1,8'h5A,1'b0,1'b0,1'b0, 0,1'b0,8'h00,1'b0};
    tbl[11] = '{1'b0,1'b0,8'h00,1'b0,1'b1,1'b0, 0,1'b0,8'h00,1'b0};
    tbl[12] = '{1'b0,1'b1,8'h66,1'b0,1'b0,1'b0, 1,1'b1,8'h66,1'b0};
    tbl[13] = '{1'b0,1'b0,8'h00,1'b0,1'b1,1'b0, 0,1'b0,8'h00,1'b0};

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].rst, tbl[i].rxv, tbl[i].rxd, tbl[i].rdy,
           tbl[i].fl, tbl[i].oclr);
      chk($sformatf("vec%0d", i), tbl[i].e_cnt, tbl[i].e_vld,
          tbl[i].e_dat, tbl[i].e_ovf);
    end

    // Fill, overflow, drain in order.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      chk($sformatf("fill%0d", i), i + 1, 1'b1, 8'h00, 1'b0);
    end
    step(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    chk("drop_aa", 16, 1'b1, 8'h00, 1'b1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d", i), 16 - i, 1'b1, 8'(i), 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("drained", 0, 1'b0, 8'h00, 1'b1);

    // Flush with concurrent push; overflow must survive.
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    end
    chk("five", 5, 1'b1, 8'h01, 1'b1);
    step(1'b0, 1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    chk("flush_push", 0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    chk("after_flush", 1, 1'b1, 8'h22, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("after_flush_pop", 0, 1'b0, 8'h00, 1'b1);

    // Clear colliding with a new drop: set wins.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
    end
    chk("refill", 16, 1'b1, 8'h80, 1'b1);
    step(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    chk("clr_vs_drop", 16, 1'b1, 8'h80, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("clr_alone", 16, 1'b1, 8'h80, 1'b0);

    // Push while full with a simultaneous pop.
    step(1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    chk("full_push_pop", 16, 1'b1, 8'h81, 1'b0);
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("drain_b%0d", i), 17 - i, 1'b1,
          8'(8'h80 + i), 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("last_55", 1, 1'b1, 8'h55, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("empty_b", 0, 1'b0, 8'h00, 1'b0);

    // Streaming with ready held high, pointers wrap.
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 8'(8'h10 + i), 1'b1, 1'b0, 1'b0);
      chk($sformatf("stream%0d", i), 1, 1'b1, 8'(8'h10 + i), 1'b0);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("stream_end", 0, 1'b0, 8'h00, 1'b0);

    // Reset mid-stream with 3 bytes stored and overflow set.
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 13; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("three_left", 3, 1'b1, 8'h0D, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("reset_mid", 0, 1'b0, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
